// File: rtl/pht_update_scheduler_if.sv
// Port bundle for pht_update_scheduler: update request, fetch read probe, PHT write port and status.
// master = the environment side (backend/fetch), slave = the scheduler.
interface pht_update_scheduler_if #(
    parameter int IDX_W = 11,
    parameter int CNT_W = 6
) ();
    logic             updValid;
    logic [IDX_W-1:0] updIndex;
    logic [1:0]       updValue;
    logic             updReady;
    logic             rdValid;
    logic [IDX_W-1:0] rdIndex;
    logic             rdStall;
    logic             phtWE;
    logic [IDX_W-1:0] phtWA;
    logic [1:0]       phtWV;
    logic             initBusy;
    logic [CNT_W-1:0] queueCount;

    modport master (
        output updValid, updIndex, updValue, rdValid, rdIndex,
        input  updReady, rdStall, phtWE, phtWA, phtWV, initBusy, queueCount
    );

    modport slave (
        input  updValid, updIndex, updValue, rdValid, rdIndex,
        output updReady, rdStall, phtWE, phtWA, phtWV, initBusy, queueCount
    );
endinterface

// File: rtl/pht_update_scheduler.sv
// Write-side PHT controller: post-reset counter init, update FIFO, bank-conflict-aware drain.
// Optional macro RSD_PHT_SCHED_STARVE_GUARD_EN forces a write (stalling fetch) after STARVE_LIMIT blocked cycles.
module pht_update_scheduler #(
    parameter int unsigned PHT_ENTRY_NUM = 2048,
    parameter int unsigned QUEUE_DEPTH   = 32,
    parameter int unsigned BANK_NUM      = 2,
    parameter logic [1:0]  INIT_VALUE    = 2'b01,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    pht_update_scheduler_if.slave bus
);
    localparam int IDX_W     = $clog2(PHT_ENTRY_NUM);
    localparam int PTR_W     = $clog2(QUEUE_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int BANK_BITS = $clog2(BANK_NUM);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(PHT_ENTRY_NUM - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             upd_ready_q, upd_ready_d;

    logic [IDX_W-1:0] idx_mem [QUEUE_DEPTH];
    logic [1:0]       val_mem [QUEUE_DEPTH];

    logic [IDX_W-1:0] head_idx;
    logic [1:0]       head_val;
    logic             bank_match;
    logic             conflict;
    logic             non_empty;
    logic             force_wr;
    logic             drain_we;
    logic             enq;
    logic             deq;

    assign head_idx  = idx_mem[head_q];
    assign head_val  = val_mem[head_q];
    assign non_empty = (count_q != '0);

    // With a single bank every fetch read collides with the write port.
    generate
        if (BANK_BITS == 0) begin : g_single_bank
            assign bank_match = 1'b1;
        end else begin : g_multi_bank
            assign bank_match = (head_idx[BANK_BITS-1:0] == bus.rdIndex[BANK_BITS-1:0]);
        end
    endgenerate

    assign conflict = bus.rdValid && bank_match;
    assign drain_we = (state_q == ST_RUN) && non_empty && (!conflict || force_wr);
    assign deq      = drain_we;
    assign enq      = (state_q == ST_RUN) && bus.updValid && upd_ready_q;

`ifdef RSD_PHT_SCHED_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;

    assign force_wr = (state_q == ST_RUN) && non_empty && conflict &&
                      (starve_q == SW'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if ((state_q != ST_RUN) || !non_empty || drain_we) begin
            starve_d = '0;
        end else if (conflict) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign bus.rdStall = force_wr;
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT == 0);
    assign force_wr    = 1'b0;
    assign bus.rdStall = 1'b0;
`endif

    assign bus.phtWE      = (state_q == ST_INIT) || drain_we;
    assign bus.phtWA      = (state_q == ST_INIT) ? init_ptr_q : head_idx;
    assign bus.phtWV      = (state_q == ST_INIT) ? INIT_VALUE : head_val;
    assign bus.initBusy   = (state_q == ST_INIT);
    assign bus.updReady   = upd_ready_q;
    assign bus.queueCount = count_q;

    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        head_d     = head_q + PTR_W'(deq);
        tail_d     = tail_q + PTR_W'(enq);
        count_d    = count_q;

        if (state_q == ST_INIT) begin
            init_ptr_d = init_ptr_q + IDX_W'(1);
            if (init_ptr_q == LAST_INDEX) begin
                state_d    = ST_RUN;
                init_ptr_d = '0;
            end
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Ready is registered, so it is derived from next-cycle occupancy.
        upd_ready_d = (state_d == ST_RUN) && (count_d != FULL_COUNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            upd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            upd_ready_q <= upd_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            idx_mem[tail_q] <= bus.updIndex;
            val_mem[tail_q] <= bus.updValue;
        end
    end
endmodule
